// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access.
// Data wins collisions, a starvation counter forces fetch, a watchdog aborts unacknowledged accesses.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddress,
    output logic [DATA_W-1:0] ifReadData,
    output logic              ifDone,
    input  logic              dRead,
    input  logic              dWrite,
    input  logic [ADDR_W-1:0] dAddress,
    input  logic [DATA_W-1:0] dWriteData,
    output logic [DATA_W-1:0] dReadData,
    output logic              dDone,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memWriteData,
    output logic              memRead,
    output logic              memWrite,
    input  logic [DATA_W-1:0] memReadData,
    input  logic              memAck,
    output logic              busError
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int WD_W     = $clog2(TIMEOUT + 1);

    localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_ONE  = STARVE_W'(1);
    localparam logic [STARVE_W-1:0] STARVE_ZERO = STARVE_W'(0);
    localparam logic [WD_W-1:0]     WD_MAX      = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]     WD_ONE      = WD_W'(1);
    localparam logic [WD_W-1:0]     WD_ZERO     = WD_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BUSY_IF = 3'd1,
        ST_BUSY_D  = 3'd2,
        ST_DONE_IF = 3'd3,
        ST_DONE_D  = 3'd4
    } state_t;

    state_t              state_r;
    logic [STARVE_W-1:0] starve_cnt_r;
    logic [WD_W-1:0]     wd_r;

    logic                d_req_s;
    logic                grant_if_s;
    logic                grant_d_s;
    logic [WD_W-1:0]     wd_next_s;
    logic                timeout_s;

    function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
        if (cnt == STARVE_MAX) begin
            return cnt;
        end else begin
            return cnt + STARVE_ONE;
        end
    endfunction

    // Fetch wins only when data is idle or data has starved it long enough.
    assign d_req_s    = dRead | dWrite;
    assign grant_if_s = ifReq & (~d_req_s | (starve_cnt_r == STARVE_MAX));
    assign grant_d_s  = d_req_s & ~grant_if_s;
    assign wd_next_s  = wd_r + WD_ONE;
    assign timeout_s  = (wd_next_s == WD_MAX);

    // Transaction FSM with all port-facing outputs registered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            starve_cnt_r <= STARVE_ZERO;
            wd_r         <= WD_ZERO;
            ifReadData   <= {DATA_W{1'b0}};
            dReadData    <= {DATA_W{1'b0}};
            ifDone       <= 1'b0;
            dDone        <= 1'b0;
            memAddress   <= {ADDR_W{1'b0}};
            memWriteData <= {DATA_W{1'b0}};
            memRead      <= 1'b0;
            memWrite     <= 1'b0;
            busError     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wd_r   <= WD_ZERO;
                    ifDone <= 1'b0;
                    dDone  <= 1'b0;
                    if (grant_if_s) begin
                        state_r      <= ST_BUSY_IF;
                        memAddress   <= ifAddress;
                        memWriteData <= {DATA_W{1'b0}};
                        memRead      <= 1'b1;
                        memWrite     <= 1'b0;
                        starve_cnt_r <= STARVE_ZERO;
                    end else if (grant_d_s) begin
                        state_r      <= ST_BUSY_D;
                        memAddress   <= dAddress;
                        memWriteData <= dWriteData;
                        memRead      <= ~dWrite;
                        memWrite     <= dWrite;
                        starve_cnt_r <= ifReq ? starve_inc(starve_cnt_r) : STARVE_ZERO;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY_IF: begin
                    if (memAck) begin
                        memRead    <= 1'b0;
                        memWrite   <= 1'b0;
                        ifReadData <= memReadData;
                        ifDone     <= 1'b1;
                        state_r    <= ST_DONE_IF;
                    end else if (timeout_s) begin
                        memRead    <= 1'b0;
                        memWrite   <= 1'b0;
                        ifReadData <= {DATA_W{1'b0}};
                        busError   <= 1'b1;
                        ifDone     <= 1'b1;
                        state_r    <= ST_DONE_IF;
                    end else begin
                        wd_r <= wd_next_s;
                    end
                end
                ST_BUSY_D: begin
                    if (memAck) begin
                        if (memRead) begin
                            dReadData <= memReadData;
                        end else begin
                            dReadData <= dReadData;
                        end
                        memRead  <= 1'b0;
                        memWrite <= 1'b0;
                        dDone    <= 1'b1;
                        state_r  <= ST_DONE_D;
                    end else if (timeout_s) begin
                        memRead   <= 1'b0;
                        memWrite  <= 1'b0;
                        dReadData <= {DATA_W{1'b0}};
                        busError  <= 1'b1;
                        dDone     <= 1'b1;
                        state_r   <= ST_DONE_D;
                    end else begin
                        wd_r <= wd_next_s;
                    end
                end
                ST_DONE_IF, ST_DONE_D: begin
                    ifDone  <= 1'b0;
                    dDone   <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ifDone   <= 1'b0;
                    dDone    <= 1'b0;
                    memRead  <= 1'b0;
                    memWrite <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
